// File: rtl/ex_muldiv_stage.sv
// RV32M-capable execute stage: single-cycle ALU, fixed-latency multiplier and
// iterative radix-2 divider feeding the EX/MEM register with valid/stall/flush.
module ex_muldiv_stage #(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [4:0]      rd,
  input  logic [31:0]     instruction,
  input  logic [4:0]      alu_op,
  input  logic            alu_src,
  input  logic            reg_write,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            mem_reg,
  input  logic            mem_stall,
  input  logic            flush,
  output logic            ex_busy,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_alu_result,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_mem_reg,
  output logic [31:0]     ex_mem_instruction
);
  localparam int  SW     = $clog2(XLEN);
  localparam int  CW     = $clog2(XLEN + MUL_LATENCY + 1);
  localparam bit  MUL_MC = (MUL_LATENCY > 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [XLEN-1:0]   r_a, r_b;
  logic [1:0]        r_op;
  logic [XLEN-1:0]   r_dq, r_rem, r_dvs;
  logic              r_div0, r_neg_q, r_neg_r;
  logic [XLEN-1:0]   r_p_rs2;
  logic [4:0]        r_p_rd;
  logic [31:0]       r_p_instr;
  logic [3:0]        r_p_ctrl;
  logic              r_valid;
  logic [XLEN-1:0]   r_result, r_rs2;
  logic [4:0]        r_rd;
  logic [31:0]       r_instr;
  logic [3:0]        r_ctrl;

  logic              w_unused_pc;
  logic [XLEN-1:0]   w_b;
  logic              w_idle, w_accept, w_is_mul, w_is_div, w_single;
  logic [XLEN-1:0]   w_ma_src, w_mb_src;
  logic [1:0]        w_mop;
  logic              w_sa, w_sb;
  logic [2*XLEN-1:0] w_ma, w_mb, w_prod;
  logic [XLEN-1:0]   w_mul_res, w_alu;
  logic              w_dsgn, w_a_neg, w_b_neg;
  logic [XLEN:0]     w_rem_sh, w_diff;
  logic              w_ge;
  logic [XLEN-1:0]   w_rem_nx, w_dq_nx, w_q_fix, w_r_fix, w_div_res;
  logic [SW-1:0]     w_sh;

  assign w_unused_pc = ^pc;
  assign w_b      = alu_src ? imm : rs2_data;
  assign w_sh     = w_b[SW-1:0];
  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = in_valid & w_idle & ~mem_stall & ~flush;
  assign w_is_mul = (alu_op[4:2] == 3'b100);
  assign w_is_div = (alu_op[4:2] == 3'b101);
  assign w_single = ~w_is_div & ~(w_is_mul & MUL_MC);

  // One multiplier shared by the single-cycle and multi-cycle paths.
  assign w_ma_src  = w_idle ? rs1_data : r_a;
  assign w_mb_src  = w_idle ? w_b : r_b;
  assign w_mop     = w_idle ? alu_op[1:0] : r_op;
  assign w_sa      = (w_mop == 2'd1) | (w_mop == 2'd2);
  assign w_sb      = (w_mop == 2'd1);
  assign w_ma      = {{XLEN{w_sa & w_ma_src[XLEN-1]}}, w_ma_src};
  assign w_mb      = {{XLEN{w_sb & w_mb_src[XLEN-1]}}, w_mb_src};
  assign w_prod    = w_ma * w_mb;
  assign w_mul_res = (w_mop == 2'd0) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  always_comb begin
    w_alu = '0;
    case (alu_op)
      5'd0:  w_alu = rs1_data + w_b;
      5'd1:  w_alu = rs1_data - w_b;
      5'd2:  w_alu = rs1_data << w_sh;
      5'd3:  w_alu = {{(XLEN-1){1'b0}}, $signed(rs1_data) < $signed(w_b)};
      5'd4:  w_alu = {{(XLEN-1){1'b0}}, rs1_data < w_b};
      5'd5:  w_alu = rs1_data ^ w_b;
      5'd6:  w_alu = rs1_data >> w_sh;
      5'd7:  w_alu = $signed(rs1_data) >>> w_sh;
      5'd8:  w_alu = rs1_data | w_b;
      5'd9:  w_alu = rs1_data & w_b;
      5'd10: w_alu = w_b;
      5'd16, 5'd17, 5'd18, 5'd19: w_alu = w_mul_res;
      default: w_alu = '0;
    endcase
  end

  // Divider works on magnitudes; odd div codes are the unsigned variants.
  assign w_dsgn  = ~alu_op[0];
  assign w_a_neg = w_dsgn & rs1_data[XLEN-1];
  assign w_b_neg = w_dsgn & w_b[XLEN-1];

  assign w_rem_sh  = {r_rem, r_dq[XLEN-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_dvs};
  assign w_ge      = ~w_diff[XLEN];
  assign w_rem_nx  = w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
  assign w_dq_nx   = {r_dq[XLEN-2:0], w_ge};
  assign w_q_fix   = r_neg_q ? -w_dq_nx : w_dq_nx;
  assign w_r_fix   = r_neg_r ? -w_rem_nx : w_rem_nx;
  assign w_div_res = r_div0 ? (r_op[1] ? r_a : '1)
                            : (r_op[1] ? w_r_fix : w_q_fix);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= '0;
      r_dq      <= '0;
      r_rem     <= '0;
      r_dvs     <= '0;
      r_div0    <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_p_rs2   <= '0;
      r_p_rd    <= '0;
      r_p_instr <= '0;
      r_p_ctrl  <= '0;
      r_valid   <= 1'b0;
      r_result  <= '0;
      r_rs2     <= '0;
      r_rd      <= '0;
      r_instr   <= '0;
      r_ctrl    <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (!mem_stall) begin
      case (r_state)
        S_IDLE: begin
          r_valid <= 1'b0;
          r_ctrl  <= '0;
          if (w_accept) begin
            r_p_rs2   <= rs2_data;
            r_p_rd    <= rd;
            r_p_instr <= instruction;
            r_p_ctrl  <= {reg_write, mem_read, mem_write, mem_reg};
            r_a       <= rs1_data;
            r_b       <= w_b;
            r_op      <= alu_op[1:0];
            r_cnt     <= '0;
            if (w_single) begin
              r_valid  <= 1'b1;
              r_result <= w_alu;
              r_rs2    <= rs2_data;
              r_rd     <= rd;
              r_instr  <= instruction;
              r_ctrl   <= {reg_write, mem_read, mem_write, mem_reg};
            end else if (w_is_div) begin
              r_state <= S_DIV;
              r_dq    <= w_a_neg ? -rs1_data : rs1_data;
              r_dvs   <= w_b_neg ? -w_b : w_b;
              r_rem   <= '0;
              r_div0  <= (w_b == '0);
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= w_a_neg;
            end else begin
              r_state <= S_MUL;
            end
          end
        end
        S_MUL: begin
          if (r_cnt == CW'(MUL_LATENCY - 2)) begin
            r_state  <= S_IDLE;
            r_valid  <= 1'b1;
            r_result <= w_mul_res;
            r_rs2    <= r_p_rs2;
            r_rd     <= r_p_rd;
            r_instr  <= r_p_instr;
            r_ctrl   <= r_p_ctrl;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DIV: begin
          r_dq  <= w_dq_nx;
          r_rem <= w_rem_nx;
          r_cnt <= r_cnt + 1'b1;
          // Last iteration folds the sign fix-up into the output load.
          if (r_cnt == CW'(XLEN - 1)) begin
            r_state  <= S_IDLE;
            r_valid  <= 1'b1;
            r_result <= w_div_res;
            r_rs2    <= r_p_rs2;
            r_rd     <= r_p_rd;
            r_instr  <= r_p_instr;
            r_ctrl   <= r_p_ctrl;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ex_busy            = ~w_idle;
  assign ex_valid           = r_valid;
  assign ex_alu_result      = r_result;
  assign ex_rs2_data        = r_rs2;
  assign ex_rd              = r_rd;
  assign ex_mem_instruction = r_instr;
  assign ex_reg_write       = r_ctrl[3];
  assign ex_mem_read        = r_ctrl[2];
  assign ex_mem_write       = r_ctrl[1];
  assign ex_mem_reg         = r_ctrl[0];
endmodule
